// File: rtl/jk_excite_driver.sv
// Queued target-bit sequencer for a jk_ff: drives J/K one target per FF edge and checks the read-back.
// Build option: define JK_TOGGLE_EN to use toggle/hold excitation instead of set/reset/hold.
module jk_excite_driver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tgt_valid,
    input  logic             i_tgt_data,
    output logic             o_tgt_ready,
    output logic             o_j,
    output logic             o_k,
    input  logic             i_ff_out,
    output logic             o_busy,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_done_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DEPTH-1:0] r_mem;
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_tgt;
    logic             r_j;
    logic             r_k;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_done_cnt;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_check;
    logic w_head;
    logic w_exc_j;
    logic w_exc_k;
    logic w_j_nxt;
    logic w_k_nxt;
    logic w_mismatch;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push     = i_tgt_valid && !w_full;
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign w_mismatch = (i_ff_out != r_tgt);

`ifdef JK_TOGGLE_EN
    assign w_exc_j = i_ff_out ^ w_head;
    assign w_exc_k = i_ff_out ^ w_head;
`else
    assign w_exc_j = !i_ff_out && w_head;
    assign w_exc_k = i_ff_out && !w_head;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_check     = 1'b0;
        w_j_nxt     = 1'b0;
        w_k_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_j_nxt     = w_exc_j;
                    w_k_nxt     = w_exc_k;
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: w_state_nxt = S_CHECK;
            S_CHECK: begin
                w_check = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_j_nxt     = w_exc_j;
                    w_k_nxt     = w_exc_k;
                    w_state_nxt = S_DRIVE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tgt      <= 1'b0;
            r_j        <= 1'b0;
            r_k        <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
            r_done_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_tgt_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_tgt    <= w_head;
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_check) begin
                r_done_cnt <= r_done_cnt + 1'b1;
                if (w_mismatch) begin
                    r_err <= 1'b1;
                    if (r_err_cnt != '1)
                        r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
        end
    end

    assign o_tgt_ready = !w_full;
    assign o_busy      = (r_state != S_IDLE) || !w_empty;
    assign o_j         = r_j;
    assign o_k         = r_k;
    assign o_err       = r_err;
    assign o_err_cnt   = r_err_cnt;
    assign o_done_cnt  = r_done_cnt;
endmodule
